// File: rtl/intercal_scatter_unit_pkg.sv
// Shared types and latency constants for the INTERCAL scatter unit
// (unmingle and bit-serial mask deposit).
package intercal_pkg;

    typedef enum logic [1:0] {
        OP_UNMINGLE  = 2'b00,
        OP_DEPOSIT32 = 2'b01,
        OP_DEPOSIT16 = 2'b10,
        OP_RESERVED  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int N_UNMINGLE = 16;
    localparam int N_DEP32    = 32;
    localparam int N_DEP16    = 16;

    // Step index of the final serial step for an op; reserved never enters BUSY.
    function automatic logic [5:0] last_step(input op_e op);
        case (op)
            OP_UNMINGLE:  last_step = 6'(N_UNMINGLE - 1);
            OP_DEPOSIT32: last_step = 6'(N_DEP32 - 1);
            OP_DEPOSIT16: last_step = 6'(N_DEP16 - 1);
            default:      last_step = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/intercal_scatter_unit_if.sv
// Request/response handshake bundle for the scatter unit; master drives
// requests and consumes results, slave is the unit itself.
interface intercal_scatter_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, f, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, f, err
    );
endinterface

// File: rtl/intercal_scatter_unit_deposit_lane.sv
// Bit-serial mask walker: one mask bit per step, consuming packed data bits
// in order wherever the mask is set. res_next_o is the result after this step.
module intercal_deposit_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] mask_i,
    output logic [W-1:0] res_next_o
);
    localparam int AW = $clog2(W);

    logic [W-1:0]  data_q;
    logic [W-1:0]  mask_q;
    logic [W-1:0]  res_q;
    logic [AW:0]   ptr_q;
    logic [AW-1:0] idx_q;
    logic          take_s;
    logic          bit_s;

    // Current deposit bit; the pointer is below W whenever the mask bit is set.
    always_comb begin
        take_s     = mask_q[idx_q];
        bit_s      = take_s ? data_q[ptr_q[AW-1:0]] : 1'b0;
        res_next_o = {bit_s, res_q[W-1:1]};
    end

    // Walker state: load clears the accumulator, each step shifts in one bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mask_q <= '0;
            res_q  <= '0;
            ptr_q  <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            mask_q <= mask_i;
            res_q  <= '0;
            ptr_q  <= '0;
            idx_q  <= '0;
        end else if (step_i) begin
            res_q  <= res_next_o;
            ptr_q  <= ptr_q + {{AW{1'b0}}, take_s};
            idx_q  <= idx_q + AW'(1);
        end
    end
endmodule

// File: rtl/intercal_scatter_unit.sv
// INTERCAL scatter unit: bit-serial unmingle and mask deposit (32-bit and
// dual 16-bit lane) behind a valid/ready handshake.
module intercal_scatter_unit
    import intercal_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    intercal_scatter_unit_if.slave  bus
);
    state_e      state_q;
    op_e         op_q;
    logic [5:0]  cnt_q;
    logic [31:0] um_src_q;
    logic [31:0] um_acc_q;
    logic        out_valid_q;
    logic [31:0] f_q;
    logic        err_q;

    logic        accept_s;
    logic        busy_s;
    op_e         op_in_s;
    logic [31:0] um_next_s;
    logic [31:0] dep32_next_s;
    logic [15:0] lo_next_s;
    logic [15:0] hi_next_s;
    logic [31:0] result_s;

    assign op_in_s   = op_e'(bus.op);
    assign accept_s  = bus.in_valid && (state_q == ST_IDLE);
    assign busy_s    = (state_q == ST_BUSY);
    // Lowest unconsumed pair of a lands at the top of each accumulator half.
    assign um_next_s = {um_src_q[1], um_acc_q[31:17], um_src_q[0], um_acc_q[15:1]};

    intercal_deposit_lane #(.W(32)) u_dep32 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .step_i     (busy_s && (op_q == OP_DEPOSIT32)),
        .data_i     (bus.a),
        .mask_i     (bus.b),
        .res_next_o (dep32_next_s)
    );

    intercal_deposit_lane #(.W(16)) u_dep16_lo (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .step_i     (busy_s && (op_q == OP_DEPOSIT16)),
        .data_i     (bus.a[15:0]),
        .mask_i     (bus.b[15:0]),
        .res_next_o (lo_next_s)
    );

    intercal_deposit_lane #(.W(16)) u_dep16_hi (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .step_i     (busy_s && (op_q == OP_DEPOSIT16)),
        .data_i     (bus.a[31:16]),
        .mask_i     (bus.b[31:16]),
        .res_next_o (hi_next_s)
    );

    // Result as it stands once the current serial step completes.
    always_comb begin
        case (op_q)
            OP_UNMINGLE:  result_s = um_next_s;
            OP_DEPOSIT32: result_s = dep32_next_s;
            OP_DEPOSIT16: result_s = {hi_next_s, lo_next_s};
            default:      result_s = 32'h0000_0000;
        endcase
    end

    // Control FSM with registered result, error flag and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_UNMINGLE;
            cnt_q       <= 6'd0;
            um_src_q    <= 32'h0000_0000;
            um_acc_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            f_q         <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q     <= op_in_s;
                        cnt_q    <= 6'd0;
                        um_src_q <= bus.a;
                        um_acc_q <= 32'h0000_0000;
                        if (op_in_s == OP_RESERVED) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            f_q         <= 32'h0000_0000;
                            err_q       <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    um_src_q <= {2'b00, um_src_q[31:2]};
                    um_acc_q <= um_next_s;
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == last_step(op_q)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        f_q         <= result_s;
                        err_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_intercal_scatter_unit.sv
// Directed bench for intercal_scatter_unit: a cycle-level reference model is
// compared every cycle, plus hand-computed results and latencies per request.
module tb_intercal_scatter_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_on = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    intercal_scatter_unit_if bus ();

    intercal_scatter_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r = 32'h0;
        int p = 0;
        case (op)
            2'b00: for (int i = 0; i < 16; i++) begin
                r[16 + i] = a[2 * i + 1];
                r[i]      = a[2 * i];
            end
            2'b01: for (int i = 0; i < 32; i++) begin
                if (b[i]) begin
                    r[i] = a[p];
                    p++;
                end
            end
            2'b10: for (int l = 0; l < 2; l++) begin
                p = 0;
                for (int i = 0; i < 16; i++) begin
                    if (b[16 * l + i]) begin
                        r[16 * l + i] = a[16 * l + p];
                        p++;
                    end
                end
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle flag, cycles since accept, expected latency and result.
    logic        m_idle = 1'b1;
    int          m_cnt  = 0;
    int          m_lat  = 0;
    logic [31:0] m_f    = 32'h0;
    logic        m_err  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_cnt  <= 0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                m_idle <= 1'b0;
                m_cnt  <= 1;
                m_lat  <= (bus.op == 2'b11) ? 1 : (bus.op == 2'b01) ? 33 : 17;
                m_f    <= ref_result(bus.op, bus.a, bus.b);
                m_err  <= (bus.op == 2'b11);
            end
        end else if (m_cnt == m_lat) begin
            if (bus.out_ready) m_idle <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_idle});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (!m_idle && m_cnt == m_lat)});
            if (!m_idle && m_cnt == m_lat) begin
                chk("model_f", bus.f, m_f);
                chk("model_err", {31'd0, bus.err}, {31'd0, m_err});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_f,
                       input logic exp_err, input int exp_lat);
        int cyc;
        issue(op, a, b);
        wait_valid(cyc);
        chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, "_f"}, bus.f, exp_f);
        chk({name, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        chk({name, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic [31:0] held_f;
        bus.in_valid = 1'b0;
        bus.op = 2'b00;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_f", bus.f, 32'h0);
        chk("reset_err", {31'd0, bus.err}, 32'd0);

        run("unmingle_aa", 2'b00, 32'hAAAA_AAAA, 32'h0, 32'hFFFF_0000, 1'b0, 17);
        run("unmingle_9", 2'b00, 32'h0000_0009, 32'h1234_5678, 32'h0002_0001, 1'b0, 17);
        run("dep32_f0", 2'b01, 32'h0000_0005, 32'hF000_0000, 32'h5000_0000, 1'b0, 33);
        run("dep32_zero", 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
        run("dep16", 2'b10, 32'h0003_0001, 32'h8001_0110, 32'h8001_0010, 1'b0, 17);
        run("reserved", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);

        // Backpressure: result held, new requests ignored.
        bus.out_ready = 1'b0;
        issue(2'b10, 32'hFFFF_FFFF, 32'h0F0F_F0F0);
        wait_valid(cyc);
        chk("bp_latency", 32'(cyc), 32'd17);
        chk("bp_f", bus.f, 32'h0F0F_F0F0);
        held_f = bus.f;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.op = 2'(i);
            bus.a = 32'h1111_1111 * i;
            bus.b = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            chk("bp_hold_f", bus.f, held_f);
            chk("bp_hold_err", {31'd0, bus.err}, 32'd0);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset at step 10 of a deposit32, with a request offered during reset.
        issue(2'b01, 32'h0000_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_busy_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_busy_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy_f", bus.f, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_no_pulse", {31'd0, bus.out_valid}, 32'd0);
        run("after_rst", 2'b01, 32'h0000_00FF, 32'h8000_0001, 32'h8000_0001, 1'b0, 33);

        // Reset wins over a simultaneous output handshake in DONE.
        bus.out_ready = 1'b0;
        issue(2'b11, 32'h0, 32'h0);
        chk("rst_done_valid_before", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_done_err", {31'd0, bus.err}, 32'd0);
        chk("rst_done_in_ready", {31'd0, bus.in_ready}, 32'd1);
        run("final_unmingle", 2'b00, 32'h5555_5555, 32'h0, 32'h0000_FFFF, 1'b0, 17);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
